// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO pointer blocks: default sizing and
// Gray/binary conversion helpers, used by both the write-side and read-side logic.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int PTR_MAX_W       = 32;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended callers decode correctly because the leading zeros XOR away.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary decoder.
// Each binary bit is the XOR of all Gray bits at or above it, computed as a prefix chain from the MSB.
module gray2bin_conv #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  assign bin_o[W-1] = gray_i[W-1];

  for (genvar i = W-2; i >= 0; i--) begin : g_pfx
    assign bin_o[i] = bin_o[i+1] ^ gray_i[i];
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/full controller for the async FIFO. It publishes a
// registered Gray write pointer and derives FULL, ALMOST_FULL, the fill level and OVERFLOW.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   RD_PTR_SYNC,
  input  logic                  CLR_OVF,
  output logic                  W_EN,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH:0]   WR_PTR_GRAY,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic [ADDR_WIDTH:0]   W_LEVEL,
  output logic                  OVERFLOW
);

  localparam int PW = ADDR_WIDTH + 1;
  // Full when the write pointer equals the read pointer with its top two Gray bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] wbin_q,  wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q,  full_d;
  logic          afull_q, afull_d;
  logic          ovf_q,   ovf_d;
  logic [PW-1:0] rbin;
  logic          w_en;

  gray2bin_conv #(.W(PW)) u_rd_g2b (
    .gray_i (RD_PTR_SYNC),
    .bin_o  (rbin)
  );

  always_comb begin
    w_en    = W_INC & ~full_q;
    wbin_d  = wbin_q + PW'(w_en);
    wgray_d = PW'(bin2gray(PTR_MAX_W'(wbin_d)));
    full_d  = (wgray_d == (RD_PTR_SYNC ^ FULL_MASK));
    level_d = wbin_d - rbin;
    afull_d = (level_d >= PW'(AFULL_THRESH));
    ovf_d   = (ovf_q & ~CLR_OVF) | (W_INC & full_q);
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign W_EN        = w_en;
  assign W_ADDR      = wbin_q[ADDR_WIDTH-1:0];
  assign WR_PTR_GRAY = wgray_q;
  assign FULL        = full_q;
  assign ALMOST_FULL = afull_q;
  assign W_LEVEL     = level_q;
  assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full (ADDR_WIDTH=3, AFULL_THRESH=6) with hand-computed expectations.
module tb_fifo_wptr_full;

  logic       CLK = 1'b0;
  logic       RST_n, W_INC, CLR_OVF;
  logic [3:0] RD_PTR_SYNC;
  logic       W_EN, FULL, ALMOST_FULL, OVERFLOW;
  logic [2:0] W_ADDR;
  logic [3:0] WR_PTR_GRAY, W_LEVEL;

  int nvec = 0;
  int nerr = 0;

  fifo_wptr_full #(.ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
    .CLK         (CLK),
    .RST_n       (RST_n),
    .W_INC       (W_INC),
    .RD_PTR_SYNC (RD_PTR_SYNC),
    .CLR_OVF     (CLR_OVF),
    .W_EN        (W_EN),
    .W_ADDR      (W_ADDR),
    .WR_PTR_GRAY (WR_PTR_GRAY),
    .FULL        (FULL),
    .ALMOST_FULL (ALMOST_FULL),
    .W_LEVEL     (W_LEVEL),
    .OVERFLOW    (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0] gtab [0:7];
  logic [3:0] prev_g, exp_g, wb;

  initial begin
    gtab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100};

    // Reset with hostile inputs
    RST_n = 1'b0; W_INC = 1'b1; CLR_OVF = 1'b0; RD_PTR_SYNC = 4'b0110;
    step(); step();
    chk("rst_addr",  32'(W_ADDR), 0);
    chk("rst_gray",  32'(WR_PTR_GRAY), 0);
    chk("rst_full",  32'(FULL), 0);
    chk("rst_afull", 32'(ALMOST_FULL), 0);
    chk("rst_level", 32'(W_LEVEL), 0);
    chk("rst_ovf",   32'(OVERFLOW), 0);
    W_INC = 1'b0; RD_PTR_SYNC = 4'b0000;
    step();
    RST_n = 1'b1;
    step();
    chk("idle_level", 32'(W_LEVEL), 0);

    // Fill to full
    for (int i = 0; i < 8; i++) begin
      W_INC = 1'b1;
      #1;
      chk("fill_wen",  32'(W_EN), 1);
      chk("fill_addr", 32'(W_ADDR), 32'(i));
      chk("fill_gray", 32'(WR_PTR_GRAY), 32'(gtab[i]));
      step();
      chk("fill_level", 32'(W_LEVEL), 32'(i + 1));
      chk("fill_afull", 32'(ALMOST_FULL), (i + 1 >= 6) ? 1 : 0);
      chk("fill_full",  32'(FULL), (i == 7) ? 1 : 0);
    end

    // Ninth request is dropped
    #1;
    chk("full_wen", 32'(W_EN), 0);
    step();
    chk("drop_addr", 32'(W_ADDR), 0);
    chk("drop_gray", 32'(WR_PTR_GRAY), 32'h0c);
    chk("drop_ovf",  32'(OVERFLOW), 1);
    chk("drop_full", 32'(FULL), 1);

    // Clear while a new overflow is attempted: set wins
    CLR_OVF = 1'b1;
    step();
    chk("ovf_setwins", 32'(OVERFLOW), 1);
    W_INC = 1'b0;
    step();
    chk("ovf_clr", 32'(OVERFLOW), 0);
    CLR_OVF = 1'b0;

    // Drain release: one read observed
    RD_PTR_SYNC = 4'b0001;
    step();
    chk("rel_full",  32'(FULL), 0);
    chk("rel_level", 32'(W_LEVEL), 7);
    chk("rel_afull", 32'(ALMOST_FULL), 1);
    W_INC = 1'b1;
    #1;
    chk("rel_wen", 32'(W_EN), 1);
    step();
    chk("refill_full",  32'(FULL), 1);
    chk("refill_level", 32'(W_LEVEL), 8);
    chk("refill_gray",  32'(WR_PTR_GRAY), 32'h0d);
    W_INC = 1'b0;

    // Simultaneous write and read at level 7 (wbin=9)
    RD_PTR_SYNC = 4'b0011;   // rbin=2
    step();
    chk("l7_level", 32'(W_LEVEL), 7);
    chk("l7_full",  32'(FULL), 0);
    W_INC = 1'b1; RD_PTR_SYNC = 4'b0010;  // rbin=3, write accepted
    step();
    chk("sim_level", 32'(W_LEVEL), 7);
    chk("sim_full",  32'(FULL), 0);
    chk("sim_addr",  32'(W_ADDR), 2);
    W_INC = 1'b0;

    // Catch reader up (wbin=10), then 16 write/read pairs through the wrap
    RD_PTR_SYNC = 4'b1111;
    step();
    chk("catch_level", 32'(W_LEVEL), 0);
    wb = 4'd10;
    for (int k = 0; k < 16; k++) begin
      prev_g      = WR_PTR_GRAY;
      W_INC       = 1'b1;
      RD_PTR_SYNC = wb ^ (wb >> 1);
      step();
      wb    = wb + 4'd1;
      exp_g = wb ^ (wb >> 1);
      chk("wrap_gray",  32'(WR_PTR_GRAY), 32'(exp_g));
      chk("wrap_1bit",  32'($countones(WR_PTR_GRAY ^ prev_g)), 1);
      chk("wrap_full",  32'(FULL), 0);
      chk("wrap_level", 32'(W_LEVEL), 1);
      if (wb == 4'd0) chk("wrap_1000", 32'(prev_g), 32'h8);
    end

    // Mid-operation reset, then release with a request pending
    RST_n = 1'b0;
    step();
    chk("mrst_gray",  32'(WR_PTR_GRAY), 0);
    chk("mrst_addr",  32'(W_ADDR), 0);
    chk("mrst_level", 32'(W_LEVEL), 0);
    RD_PTR_SYNC = 4'b0000;
    RST_n = 1'b1;
    #1;
    chk("post_rst_wen", 32'(W_EN), 1);
    step();
    chk("post_rst_addr", 32'(W_ADDR), 1);
    chk("post_rst_gray", 32'(WR_PTR_GRAY), 1);
    W_INC = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule
